enc_dec_apb_regs: RTL and testbench
===================================

// Module: enc_dec_apb_regs
// PURPOSE
// APB3 responder (slave) register bank for the encoder/decoder core; the bus-facing end of the
// control interface consumed by the controller (regs_wr_en, paddr, ctrl_reg).
// Holds CTRL/DATA_IN/CODEWORD_WIDTH/NOISE, captures result on operation_done,
// stalls bus writes (wait states) while an operation is in flight, flags bad accesses.
// PARAMETERS
// AMBA_ADDR_WIDTH  32  APB address width
// AMBA_WORD        32  APB data width and register width
// PORTS
// clk             in   1                one clock, all logic on posedge
// rst             in   1                synchronous reset, active-high
// psel            in   1                APB select
// penable         in   1                APB access phase
// pwrite          in   1                1 write, 0 read
// paddr           in   AMBA_ADDR_WIDTH  byte address
// pwdata          in   AMBA_WORD        write data
// prdata          out  AMBA_WORD        read data
// pready          out  1                transfer complete
// pslverr         out  1                transfer error
// regs_wr_en      out  1                accepted register write this cycle
// paddr_out       out  AMBA_ADDR_WIDTH  paddr passthrough (comb) for controller decode
// ctrl_reg        out  AMBA_WORD        CTRL, bits[1:0] live, rest 0
// data_in_reg     out  AMBA_WORD        DATA_IN
// cw_width_reg    out  AMBA_WORD        CODEWORD_WIDTH, bits[1:0] live
// noise_reg       out  AMBA_WORD        NOISE
// data_out        in   AMBA_WORD        core result
// num_of_errors   in   2                core error count
// operation_done  in   1                1-cycle pulse, result valid
// BEHAVIOUR
// - Map (offset, word-aligned): 0x00 CTRL rw, 0x04 DATA_IN rw, 0x08 CODEWORD_WIDTH rw,
//   0x0C NOISE rw, 0x10 DATA_OUT ro, 0x14 STATUS ro = {..0, busy[2], num_err[1:0]}.
// - Phase FSM: IDLE (psel=0) -> SETUP (psel&~penable) -> ACCESS (psel&penable);
//   ACCESS holds while pready=0; pready=1 -> SETUP if psel stays high, else IDLE.
// - pready (comb, ACCESS only) = ~(pwrite & busy); 0 outside ACCESS. Reads never stall.
// - regs_wr_en (comb) = ACCESS & pwrite & pready & ~pslverr; target reg updates at that edge.
// - pslverr (comb, ACCESS with pready=1): unmapped offset, paddr[1:0]!=0, or write to 0x10/0x14;
//   no register change, prdata=0.
// - prdata (comb) = selected reg when ACCESS & ~pwrite & pready & ~pslverr, else 0.
// - busy: set at edge where CTRL write accepted; cleared at edge where operation_done=1.
//   Set and clear same edge -> set wins. Writes to any address stall while busy.
// - Capture: operation_done=1 -> DATA_OUT<=data_out, num_err<=num_of_errors at that edge.
// - operation_done stalls a write only until the next cycle: busy=0 next cycle -> pready=1.
// - Reset (any cycle, incl. mid-stall): all regs, busy, captured result = 0; pready=0;
//   pslverr=0; regs_wr_en=0; in-flight transfer dropped, master must restart it.
// - Unused upper bits of CTRL/CODEWORD_WIDTH ignored on write, read as 0.
// TESTING
// - Reset: rst=1 two cycles -> all reg outputs 0, prdata=0, pready=0, STATUS reads 0x0.
// - Write DATA_IN=0xA5A5_0001 -> 1 ACCESS cycle, pready=1, regs_wr_en=1, data_in_reg=0xA5A5_0001
//   next cycle; readback returns same, pslverr=0.
// - Write CTRL=0x2 -> busy=1; write NOISE=0x4 stalls (pready=0) 5 cycles; pulse operation_done
//   with data_out=0x0000_00B3, num_of_errors=1 -> pready=1 next cycle; DATA_OUT=0xB3, STATUS=0x1.
// - Read 0x18 and write 0x14 -> pslverr=1, pready=1, prdata=0, no reg change, regs_wr_en=0.
// - Unaligned paddr=0x06 write -> pslverr=1, DATA_IN unchanged.
// - rst=1 during stalled write with busy=1 -> busy=0, regs 0; after release, fresh write completes
//   in 1 ACCESS cycle.

Source files
------------

// File: rtl/enc_dec_apb_regs.sv
// APB3 register bank for the encoder/decoder core.
// Holds control registers, captures results, stalls writes while busy.
module enc_dec_apb_regs #(
   parameter int AMBA_ADDR_WIDTH = 32,
   parameter int AMBA_WORD       = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       psel,
   input  logic                       penable,
   input  logic                       pwrite,
   input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
   input  logic [AMBA_WORD-1:0]       pwdata,
   output logic [AMBA_WORD-1:0]       prdata,
   output logic                       pready,
   output logic                       pslverr,
   output logic                       regs_wr_en,
   output logic [AMBA_ADDR_WIDTH-1:0] paddr_out,
   output logic [AMBA_WORD-1:0]       ctrl_reg,
   output logic [AMBA_WORD-1:0]       data_in_reg,
   output logic [AMBA_WORD-1:0]       cw_width_reg,
   output logic [AMBA_WORD-1:0]       noise_reg,
   input  logic [AMBA_WORD-1:0]       data_out,
   input  logic [1:0]                 num_of_errors,
   input  logic                       operation_done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } phase_t;

   phase_t state;
   phase_t state_n;
   phase_t phase;

   logic [1:0]           ctrl_q;
   logic [AMBA_WORD-1:0] data_in_q;
   logic [1:0]           cw_q;
   logic [AMBA_WORD-1:0] noise_q;
   logic [AMBA_WORD-1:0] dout_q;
   logic [1:0]           nerr_q;
   logic                 busy;

   logic [2:0] idx;
   logic       mapped;
   logic       aligned;
   logic       bad;
   logic       access;

   // Decode a 256-byte window; higher address bits belong to the system decoder.
   assign idx     = paddr[4:2];
   assign mapped  = (paddr[7:5] == 3'd0) && (idx <= 3'd5);
   assign aligned = (paddr[1:0] == 2'b00);
   assign bad     = ~mapped | ~aligned | (pwrite & idx[2]);

   assign paddr_out    = paddr;
   assign ctrl_reg     = {{(AMBA_WORD-2){1'b0}}, ctrl_q};
   assign data_in_reg  = data_in_q;
   assign cw_width_reg = {{(AMBA_WORD-2){1'b0}}, cw_q};
   assign noise_reg    = noise_q;
   assign access       = (phase == ACCESS);

   // An access phase is only honoured after a setup phase seen since reset.
   always_comb begin
      phase = IDLE;
      if (!rst && psel) begin
         if (!penable) begin
            phase = SETUP;
         end else if (state != IDLE) begin
            phase = ACCESS;
         end
      end
   end

   always_comb begin
      pready     = 1'b0;
      pslverr    = 1'b0;
      regs_wr_en = 1'b0;
      prdata     = '0;
      state_n    = phase;
      if (access) begin
         pready = ~(pwrite & busy);
         if (pready) begin
            pslverr    = bad;
            regs_wr_en = pwrite & ~bad;
            state_n    = psel ? SETUP : IDLE;
            if (!pwrite && !bad) begin
               unique case (idx)
                  3'd0:    prdata = ctrl_reg;
                  3'd1:    prdata = data_in_q;
                  3'd2:    prdata = cw_width_reg;
                  3'd3:    prdata = noise_q;
                  3'd4:    prdata = dout_q;
                  default: prdata = {{(AMBA_WORD-3){1'b0}}, busy, nerr_q};
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q    <= '0;
         data_in_q <= '0;
         cw_q      <= '0;
         noise_q   <= '0;
         dout_q    <= '0;
         nerr_q    <= '0;
         busy      <= 1'b0;
      end else begin
         if (operation_done) begin
            dout_q <= data_out;
            nerr_q <= num_of_errors;
            busy   <= 1'b0;
         end
         if (regs_wr_en) begin
            unique case (idx)
               3'd0: begin
                  ctrl_q <= pwdata[1:0];
                  busy   <= 1'b1;
               end
               3'd1:    data_in_q <= pwdata;
               3'd2:    cw_q      <= pwdata[1:0];
               default: noise_q   <= pwdata;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_enc_dec_apb_regs.sv
// Directed bench for enc_dec_apb_regs.
// Each task drives one scenario and checks results inline.
module tb_enc_dec_apb_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        regs_wr_en;
   logic [31:0] paddr_out;
   logic [31:0] ctrl_reg;
   logic [31:0] data_in_reg;
   logic [31:0] cw_width_reg;
   logic [31:0] noise_reg;
   logic [31:0] data_out = '0;
   logic [1:0]  num_of_errors = '0;
   logic        operation_done = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   enc_dec_apb_regs dut (
      .clk(clk),
      .rst(rst),
      .psel(psel),
      .penable(penable),
      .pwrite(pwrite),
      .paddr(paddr),
      .pwdata(pwdata),
      .prdata(prdata),
      .pready(pready),
      .pslverr(pslverr),
      .regs_wr_en(regs_wr_en),
      .paddr_out(paddr_out),
      .ctrl_reg(ctrl_reg),
      .data_in_reg(data_in_reg),
      .cw_width_reg(cw_width_reg),
      .noise_reg(noise_reg),
      .data_out(data_out),
      .num_of_errors(num_of_errors),
      .operation_done(operation_done)
   );

   always #5 clk = ~clk;

   // One APB transfer; reports completion-cycle outputs and wait states.
   task automatic xfer(input logic w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic err, output logic wen,
                       output int waits);
      @(posedge clk);
      #1 psel = 1'b1; penable = 1'b0;
      pwrite = w; paddr = a; pwdata = d;
      @(posedge clk);
      #1 penable = 1'b1;
      waits = 0;
      rd = '0; err = 1'b0; wen = 1'b0;
      forever begin
         @(negedge clk);
         if (pready) begin
            rd = prdata; err = pslverr; wen = regs_wr_en;
            break;
         end
         waits++;
         if (waits > 50) begin
            vectors++; miscompares++;
            $display("FAIL timeout addr=%h pready stuck at 0", a);
            break;
         end
      end
      @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] rd; logic err, wen; int wt;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({ctrl_reg, data_in_reg, cw_width_reg, noise_reg} !== '0) begin
         miscompares++;
         $display("FAIL reset_regs got=%h/%h/%h/%h want=0",
                  ctrl_reg, data_in_reg, cw_width_reg, noise_reg);
      end
      vectors++;
      if (prdata !== 32'h0 || pready !== 1'b0 || pslverr !== 1'b0 ||
          regs_wr_en !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_bus got prdata=%h pready=%b err=%b wen=%b want 0",
                  prdata, pready, pslverr, regs_wr_en);
      end
      #1 rst = 1'b0;
      xfer(1'b0, 32'h14, 32'h0, rd, err, wen, wt);
      vectors++;
      if (rd !== 32'h0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_status got=%h err=%b want=0 err=0", rd, err);
      end
   endtask

   task automatic test_data_in;
      logic [31:0] rd; logic err, wen; int wt;
      xfer(1'b1, 32'h04, 32'hA5A5_0001, rd, err, wen, wt);
      vectors++;
      if (wt !== 0 || wen !== 1'b1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL data_in_wr got waits=%0d wen=%b err=%b want 0/1/0",
                  wt, wen, err);
      end
      vectors++;
      if (data_in_reg !== 32'hA5A5_0001) begin
         miscompares++;
         $display("FAIL data_in_reg got=%h want=a5a50001", data_in_reg);
      end
      xfer(1'b0, 32'h04, 32'h0, rd, err, wen, wt);
      vectors++;
      if (rd !== 32'hA5A5_0001 || err !== 1'b0 || wen !== 1'b0) begin
         miscompares++;
         $display("FAIL data_in_rd got=%h err=%b wen=%b want=a5a50001/0/0",
                  rd, err, wen);
      end
   endtask

   task automatic test_unused_bits;
      logic [31:0] rd; logic err, wen; int wt;
      xfer(1'b1, 32'h08, 32'hFFFF_FFFF, rd, err, wen, wt);
      vectors++;
      if (cw_width_reg !== 32'h3) begin
         miscompares++;
         $display("FAIL cw_width_reg got=%h want=3", cw_width_reg);
      end
      xfer(1'b0, 32'h08, 32'h0, rd, err, wen, wt);
      vectors++;
      if (rd !== 32'h3) begin
         miscompares++;
         $display("FAIL cw_width_rd got=%h want=3", rd);
      end
   endtask

   task automatic test_stall;
      logic [31:0] rd; logic err, wen; int wt;
      xfer(1'b1, 32'h00, 32'h2, rd, err, wen, wt);
      vectors++;
      if (ctrl_reg !== 32'h2 || wt !== 0) begin
         miscompares++;
         $display("FAIL ctrl_wr got=%h waits=%0d want=2/0", ctrl_reg, wt);
      end
      xfer(1'b0, 32'h14, 32'h0, rd, err, wen, wt);
      vectors++;
      if (rd !== 32'h4 || wt !== 0) begin
         miscompares++;
         $display("FAIL busy_status got=%h waits=%0d want=4/0", rd, wt);
      end
      fork
         xfer(1'b1, 32'h0C, 32'h4, rd, err, wen, wt);
         begin
            repeat (6) @(posedge clk);
            #1 operation_done = 1'b1;
            data_out = 32'h0000_00B3; num_of_errors = 2'd1;
            @(posedge clk);
            #1 operation_done = 1'b0;
            data_out = '0; num_of_errors = '0;
         end
      join
      vectors++;
      if (wt !== 5 || wen !== 1'b1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL stall got waits=%0d wen=%b err=%b want 5/1/0",
                  wt, wen, err);
      end
      vectors++;
      if (noise_reg !== 32'h4) begin
         miscompares++;
         $display("FAIL noise_reg got=%h want=4", noise_reg);
      end
      xfer(1'b0, 32'h10, 32'h0, rd, err, wen, wt);
      vectors++;
      if (rd !== 32'hB3) begin
         miscompares++;
         $display("FAIL data_out_rd got=%h want=b3", rd);
      end
      xfer(1'b0, 32'h14, 32'h0, rd, err, wen, wt);
      vectors++;
      if (rd !== 32'h1) begin
         miscompares++;
         $display("FAIL status_done got=%h want=1", rd);
      end
   endtask

   task automatic test_errors;
      logic [31:0] rd; logic err, wen; int wt;
      xfer(1'b0, 32'h18, 32'h0, rd, err, wen, wt);
      vectors++;
      if (err !== 1'b1 || rd !== 32'h0 || wt !== 0 || wen !== 1'b0) begin
         miscompares++;
         $display("FAIL rd_unmapped got err=%b rd=%h waits=%0d wen=%b want 1/0/0/0",
                  err, rd, wt, wen);
      end
      xfer(1'b1, 32'h14, 32'hFFFF_FFFF, rd, err, wen, wt);
      vectors++;
      if (err !== 1'b1 || wen !== 1'b0 || wt !== 0) begin
         miscompares++;
         $display("FAIL wr_status got err=%b wen=%b waits=%0d want 1/0/0",
                  err, wen, wt);
      end
      xfer(1'b0, 32'h14, 32'h0, rd, err, wen, wt);
      vectors++;
      if (rd !== 32'h1) begin
         miscompares++;
         $display("FAIL status_kept got=%h want=1", rd);
      end
      xfer(1'b1, 32'h06, 32'h1234_5678, rd, err, wen, wt);
      vectors++;
      if (err !== 1'b1 || wen !== 1'b0 || data_in_reg !== 32'hA5A5_0001) begin
         miscompares++;
         $display("FAIL unaligned got err=%b wen=%b data_in=%h want 1/0/a5a50001",
                  err, wen, data_in_reg);
      end
   endtask

   task automatic test_reset_mid_stall;
      logic [31:0] rd; logic err, wen; int wt;
      xfer(1'b1, 32'h00, 32'h1, rd, err, wen, wt);
      @(posedge clk);
      #1 psel = 1'b1; penable = 1'b0;
      pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 penable = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (pready !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_stall got pready=%b want=0", pready);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (pready !== 1'b0 || regs_wr_en !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_bus got pready=%b wen=%b want 0/0",
                  pready, regs_wr_en);
      end
      @(posedge clk);
      #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
      vectors++;
      if (ctrl_reg !== 32'h0 || data_in_reg !== 32'h0 || cw_width_reg !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_regs got ctrl=%h din=%h cw=%h want 0",
                  ctrl_reg, data_in_reg, cw_width_reg);
      end
      xfer(1'b1, 32'h04, 32'h0000_5A5A, rd, err, wen, wt);
      vectors++;
      if (wt !== 0 || wen !== 1'b1 || data_in_reg !== 32'h5A5A) begin
         miscompares++;
         $display("FAIL post_rst_wr got waits=%0d wen=%b din=%h want 0/1/5a5a",
                  wt, wen, data_in_reg);
      end
      xfer(1'b0, 32'h14, 32'h0, rd, err, wen, wt);
      vectors++;
      if (rd !== 32'h0) begin
         miscompares++;
         $display("FAIL post_rst_status got=%h want=0", rd);
      end
   endtask

   initial begin
      test_reset();
      test_data_in();
      test_unused_bits();
      test_stall();
      test_errors();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
